// File: rtl/pp_gen_seq.sv
// Sequential partial-product generator: one shared HxH multiplier produces the
// four W-bit sub-products over four cycles. Optional macro: PP_GEN_APPROX_LL_EN.
module pp_gen_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_x,
  input  logic [W-1:0] op_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] pp_a,
  output logic [W-1:0] pp_b,
  output logic [W-1:0] pp_c,
  output logic [W-1:0] pp_d
);

  localparam int H = W / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     step_q, step_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   pp_a_q, pp_a_d;
  logic [W-1:0]   pp_b_q, pp_b_d;
  logic [W-1:0]   pp_c_q, pp_c_d;
  logic [W-1:0]   pp_d_q, pp_d_d;

  logic [H-1:0]   x_lo, x_hi, y_lo, y_hi;
  logic [H-1:0]   mul_a, mul_b;
  logic [W-1:0]   prod;

  assign x_lo = x_q[H-1:0];
  assign x_hi = x_q[W-1:H];
  assign y_lo = y_q[H-1:0];
  assign y_hi = y_q[W-1:H];

  // Operand select for the shared multiplier, driven by the step counter.
  always_comb begin
    mul_a = x_lo;
    mul_b = y_lo;
    case (step_q)
      2'd0: begin
`ifdef PP_GEN_APPROX_LL_EN
        mul_a = {x_lo[H-1:H/2], {(H/2){1'b0}}};
        mul_b = {y_lo[H-1:H/2], {(H/2){1'b0}}};
`else
        mul_a = x_lo;
        mul_b = y_lo;
`endif
      end
      2'd1: begin
        mul_a = x_lo;
        mul_b = y_hi;
      end
      2'd2: begin
        mul_a = x_hi;
        mul_b = y_lo;
      end
      default: begin
        mul_a = x_hi;
        mul_b = y_hi;
      end
    endcase
  end

  // Full 2H-bit product; zero-extension keeps every product bit.
  assign prod = {{H{1'b0}}, mul_a} * {{H{1'b0}}, mul_b};

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;
    pp_a_d  = pp_a_q;
    pp_b_d  = pp_b_q;
    pp_c_d  = pp_c_q;
    pp_d_d  = pp_d_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = op_x;
          y_d     = op_y;
          step_d  = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        step_d = step_q + 2'd1;
        case (step_q)
          2'd0:    pp_b_d = prod;
          2'd1:    pp_c_d = prod;
          2'd2:    pp_d_d = prod;
          default: begin
            pp_a_d  = prod;
            step_d  = 2'd0;
            state_d = DONE;
          end
        endcase
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
      pp_a_q  <= '0;
      pp_b_q  <= '0;
      pp_c_q  <= '0;
      pp_d_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pp_a_q  <= pp_a_d;
      pp_b_q  <= pp_b_d;
      pp_c_q  <= pp_c_d;
      pp_d_q  <= pp_d_d;
    end
  end

  // Handshake flags decode registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign pp_a      = pp_a_q;
  assign pp_b      = pp_b_q;
  assign pp_c      = pp_c_q;
  assign pp_d      = pp_d_q;

endmodule
